// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit with valid/ready handshakes on both sides.
// The carry chain is cut into STAGES chunks of WIDTH/STAGES bits, one chunk per clock.
// Optional signed-overflow and zero flags are built when PIPELINED_ADDER_FLAGS_EN is defined;
// otherwise OV and Z are tied low and the ports remain for drop-in compatibility.
module pipelined_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    input  logic             SUB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] SO,
    output logic             CO,
    output logic             OV,
    output logic             Z
);

    localparam int unsigned CW   = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    // Stage registers; entry k is the state held after stage k.
    logic [STAGES-1:0][WIDTH-1:0] a_q;
    logic [STAGES-1:0][WIDTH-1:0] b_q;
    logic [STAGES-1:0][WIDTH-1:0] s_q;
    logic [STAGES-1:0]            c_q;
    logic [STAGES-1:0]            vld_q;

    // Stage inputs: entry 0 is the incoming beat, entry k is stage k-1's registers.
    logic [STAGES:0][WIDTH-1:0] a_in;
    logic [STAGES:0][WIDTH-1:0] b_in;
    logic [STAGES:0][WIDTH-1:0] s_in;
    logic [STAGES:0]            c_in;
    logic [STAGES:0]            v_in;

    logic [STAGES-1:0][CW:0]      chunk;
    logic [STAGES-1:0][WIDTH-1:0] ns;
    logic [STAGES-1:0]            nc;

    logic [WIDTH-1:0] beff;
    logic             c0;
    logic             adv;

    // Whole pipeline moves together unless the output beat is blocked.
    assign adv       = !vld_q[LAST] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[LAST];
    assign SO        = s_q[LAST];
    assign CO        = c_q[LAST];

    // Operand conditioning and the per-stage chunk adders.
    always_comb begin
        beff  = SUB ? ~B : B;
        c0    = SUB ? 1'b1 : CI;
        a_in  = {a_q, A};
        b_in  = {b_q, beff};
        s_in  = {s_q, WIDTH'(0)};
        c_in  = {c_q, c0};
        v_in  = {vld_q, in_valid};
        chunk = '0;
        ns    = '0;
        nc    = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            chunk[k] = (CW+1)'(a_in[k][k*CW +: CW]) + (CW+1)'(b_in[k][k*CW +: CW])
                     + (CW+1)'(c_in[k]);
            ns[k]    = s_in[k] | (WIDTH'(chunk[k][CW-1:0]) << (k*CW));
            nc[k]    = chunk[k][CW];
        end
    end

    // Stage registers; data only loads behind a valid beat so bubbles leave outputs untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            c_q   <= '0;
            vld_q <= '0;
        end else if (adv) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                vld_q[k] <= v_in[k];
                if (v_in[k]) begin
                    a_q[k] <= a_in[k];
                    b_q[k] <= b_in[k];
                    s_q[k] <= ns[k];
                    c_q[k] <= nc[k];
                end
            end
        end
    end

    // Operand bits already consumed by earlier chunks are carried but never read.
    logic unused_operand_bits;
    assign unused_operand_bits = ^{a_q, b_q};

`ifdef PIPELINED_ADDER_FLAGS_EN
    logic ov_q;
    logic z_q;

    // Flags register with the final sum so they share its timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_q <= 1'b0;
            z_q  <= 1'b0;
        end else if (adv && v_in[LAST]) begin
            ov_q <= (a_in[LAST][WIDTH-1] == b_in[LAST][WIDTH-1])
                 && (ns[LAST][WIDTH-1] != a_in[LAST][WIDTH-1]);
            z_q  <= (ns[LAST] == '0);
        end
    end

    assign OV = ov_q;
    assign Z  = z_q;
`else
    assign OV = 1'b0;
    assign Z  = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and randomised checks for pipelined_adder at several WIDTH/STAGES points.
module tb_pipelined_adder;

`ifdef PIPELINED_ADDER_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    // Main 32/4 instance.
    logic        in_valid, in_ready, ci, sub, out_valid, out_ready, co, ov, z;
    logic [31:0] a, b, so;

    pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .CI(ci), .SUB(sub), .out_valid(out_valid), .out_ready(out_ready),
        .SO(so), .CO(co), .OV(ov), .Z(z)
    );

    // Sweep instances share one stimulus bus; sel picks the active one.
    int          sel = -1;
    logic        sw_valid, sw_ci, sw_sub, sw_ready;
    logic [63:0] sw_a, sw_b;
    logic        r0_ir, r0_ov_, r0_co, r0_ovf, r0_z;
    logic        r1_ir, r1_ov_, r1_co, r1_ovf, r1_z;
    logic        r2_ir, r2_ov_, r2_co, r2_ovf, r2_z;
    logic [7:0]  r0_so, r1_so;
    logic [63:0] r2_so;

    pipelined_adder #(.WIDTH(8), .STAGES(1)) u8x1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid && sel == 0), .in_ready(r0_ir),
        .A(sw_a[7:0]), .B(sw_b[7:0]), .CI(sw_ci), .SUB(sw_sub), .out_valid(r0_ov_),
        .out_ready(sw_ready), .SO(r0_so), .CO(r0_co), .OV(r0_ovf), .Z(r0_z)
    );
    pipelined_adder #(.WIDTH(8), .STAGES(8)) u8x8 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid && sel == 1), .in_ready(r1_ir),
        .A(sw_a[7:0]), .B(sw_b[7:0]), .CI(sw_ci), .SUB(sw_sub), .out_valid(r1_ov_),
        .out_ready(sw_ready), .SO(r1_so), .CO(r1_co), .OV(r1_ovf), .Z(r1_z)
    );
    pipelined_adder #(.WIDTH(64), .STAGES(4)) u64x4 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid && sel == 2), .in_ready(r2_ir),
        .A(sw_a), .B(sw_b), .CI(sw_ci), .SUB(sw_sub), .out_valid(r2_ov_),
        .out_ready(sw_ready), .SO(r2_so), .CO(r2_co), .OV(r2_ovf), .Z(r2_z)
    );

    logic        m_ir, m_ov, m_co;
    logic [63:0] m_so;
    always_comb begin
        m_ir = r0_ir; m_ov = r0_ov_; m_so = 64'(r0_so); m_co = r0_co;
        if (sel == 1) begin m_ir = r1_ir; m_ov = r1_ov_; m_so = 64'(r1_so); m_co = r1_co; end
        if (sel == 2) begin m_ir = r2_ir; m_ov = r2_ov_; m_so = r2_so; m_co = r2_co; end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one beat into the idle main pipeline and wait for its result.
    task automatic send_one(input logic [31:0] ia, input logic [31:0] ib, input logic ici,
                            input logic isub, output int lat, output logic [31:0] rso,
                            output logic rco, output logic rov, output logic rz);
        in_valid = 1'b1; a = ia; b = ib; ci = ici; sub = isub; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        rso = so; rco = co; rov = ov; rz = z;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; ci = 1'b0; sub = 1'b0;
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b0 || so !== 32'h0 || co !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset_hold: out_valid=%b so=%h co=%b in_ready=%b expected 0 0 0 1",
                     out_valid, so, co, in_ready);
        if (out_valid !== 1'b0 || so !== 32'h0 || co !== 1'b0 || in_ready !== 1'b1) errors++;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || so !== 32'h0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: out_valid=%b in_ready=%b so=%h expected 0 1 0",
                         i, out_valid, in_ready, so);
            end
        end
    endtask

    task automatic test_latency();
        int lat; logic [31:0] rso; logic rco, rov, rz;
        send_one(32'h0000FFFF, 32'h1, 1'b0, 1'b0, lat, rso, rco, rov, rz);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL latency: got %0d expected 4", lat); end
        checks++;
        if (rso !== 32'h00010000 || rco !== 1'b0) begin
            errors++;
            $display("FAIL chunk_carry: got so=%h co=%b expected 00010000 0", rso, rco);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_wrap();
        int lat; logic [31:0] rso; logic rco, rov, rz;
        logic [31:0] va [6] = '{32'hFFFFFFFF, 32'd5, 32'h7FFFFFFF, 32'h1234, 32'd9, 32'h80000000};
        logic [31:0] vb [6] = '{32'h0, 32'd7, 32'h1, 32'h1234, 32'd4, 32'h1};
        logic        vc [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        vs [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] es [6] = '{32'h0, 32'hFFFFFFFE, 32'h80000000, 32'h0, 32'd5, 32'h7FFFFFFF};
        logic        ec [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        eo [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        ez [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            send_one(va[i], vb[i], vc[i], vs[i], lat, rso, rco, rov, rz);
            checks++;
            if (rso !== es[i] || rco !== ec[i]) begin
                errors++;
                $display("FAIL wrap[%0d]: got so=%h co=%b expected so=%h co=%b",
                         i, rso, rco, es[i], ec[i]);
            end
            checks++;
            if (rov !== (eo[i] & FLAGS) || rz !== (ez[i] & FLAGS)) begin
                errors++;
                $display("FAIL flags[%0d]: got ov=%b z=%b expected ov=%b z=%b",
                         i, rov, rz, eo[i] & FLAGS, ez[i] & FLAGS);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ta [10] = '{32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h12345678, 32'd10,
                                 32'd3, 32'h0000FFFF, 32'h80000000, 32'hFFFF0000, 32'd0};
        logic [31:0] tb [10] = '{32'd2, 32'd1, 32'h80000000, 32'h11111111, 32'd3,
                                 32'd10, 32'h0000FFFF, 32'd1, 32'h0000FFFF, 32'd0};
        logic        tc [10] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 1};
        logic        ts [10] = '{0, 0, 0, 0, 1, 1, 0, 1, 0, 1};
        logic [31:0] es [10] = '{32'd3, 32'h0, 32'h0, 32'h23456789, 32'd7,
                                 32'hFFFFFFF9, 32'h0001FFFF, 32'h7FFFFFFF, 32'h0, 32'h0};
        logic        ec [10] = '{0, 1, 1, 0, 1, 0, 0, 1, 1, 1};
        int sent = 0, recv = 0;
        logic held = 1'b0;
        logic [31:0] held_so = '0;
        for (int cyc = 0; cyc < 200 && recv < 10; cyc++) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            in_valid  = (sent < 10);
            if (sent < 10) begin a = ta[sent]; b = tb[sent]; ci = tc[sent]; sub = ts[sent]; end
            #1;
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || so !== held_so) begin
                    errors++;
                    $display("FAIL stall_hold: out_valid=%b so=%h expected 1 %h",
                             out_valid, so, held_so);
                end
            end
            held = 1'b0;
            if (out_valid && !out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_ready: in_ready=%b expected 0", in_ready);
                end
                held = 1'b1;
                held_so = so;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (so !== es[recv] || co !== ec[recv]) begin
                    errors++;
                    $display("FAIL stream[%0d]: got so=%h co=%b expected so=%h co=%b",
                             recv, so, co, es[recv], ec[recv]);
                end
                recv++;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (recv !== 10) begin errors++; $display("FAIL stream_count: got %0d expected 10", recv); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stream_extra[%0d]: out_valid=%b expected 0", i, out_valid);
            end
            tick();
        end
    endtask

    task automatic test_mid_reset();
        int lat; logic [31:0] rso; logic rco, rov, rz;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 32'(i + 1); b = 32'h10; ci = 1'b0; sub = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || so !== 32'h11) begin
            errors++;
            $display("FAIL inflight: out_valid=%b so=%h expected 1 00000011", out_valid, so);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || so !== 32'h0 || co !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: out_valid=%b so=%h co=%b in_ready=%b expected 0 0 0 1",
                     out_valid, so, co, in_ready);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stale_beat[%0d]: out_valid=%b expected 0", i, out_valid);
            end
        end
        send_one(32'd100, 32'd23, 1'b0, 1'b0, lat, rso, rco, rov, rz);
        checks++;
        if (lat !== 4 || rso !== 32'd123 || rco !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: got lat=%0d so=%h co=%b expected 4 0000007b 0",
                     lat, rso, rco);
        end
    endtask

    task automatic test_param_sweep(input int s, input int w);
        logic [63:0] q_so [$];
        logic        q_co [$];
        logic [63:0] m, am, bm, e_so;
        logic [64:0] full;
        logic        e_co;
        int acc = 0;
        sel = s;
        m = (w == 64) ? 64'hFFFFFFFF_FFFFFFFF : ((64'd1 << w) - 64'd1);
        for (int cyc = 0; cyc < 6000 && !(acc == 1000 && q_so.size() == 0); cyc++) begin
            sw_valid = (acc < 1000) && ($urandom_range(0, 3) != 0);
            sw_a     = {$urandom, $urandom};
            sw_b     = {$urandom, $urandom};
            sw_ci    = 1'($urandom_range(0, 1));
            sw_sub   = 1'($urandom_range(0, 1));
            sw_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (m_ov && sw_ready) begin
                checks++;
                if (q_so.size() == 0) begin
                    errors++;
                    $display("FAIL sweep%0d_spurious: so=%h with no beat outstanding", s, m_so);
                end else begin
                    e_so = q_so.pop_front();
                    e_co = q_co.pop_front();
                    if (m_so !== e_so || m_co !== e_co) begin
                        errors++;
                        $display("FAIL sweep%0d: got so=%h co=%b expected so=%h co=%b",
                                 s, m_so, m_co, e_so, e_co);
                    end
                end
            end
            if (sw_valid && m_ir) begin
                am = sw_a & m;
                bm = sw_b & m;
                if (sw_sub) full = {1'b0, am} + {1'b0, ~sw_b & m} + 65'd1;
                else        full = {1'b0, am} + {1'b0, bm} + 65'(sw_ci);
                q_so.push_back(full[63:0] & m);
                q_co.push_back(full[w]);
                acc++;
            end
            tick();
        end
        sw_valid = 1'b0;
        checks++;
        if (acc != 1000 || q_so.size() != 0) begin
            errors++;
            $display("FAIL sweep%0d_drain: accepted=%0d outstanding=%0d expected 1000 0",
                     s, acc, q_so.size());
        end
    endtask

    initial begin
        sw_valid = 1'b0; sw_ready = 1'b1; sw_a = '0; sw_b = '0; sw_ci = 1'b0; sw_sub = 1'b0;
        test_reset();
        test_latency();
        test_wrap();
        test_back_to_back();
        test_mid_reset();
        test_param_sweep(0, 8);
        test_param_sweep(1, 8);
        test_param_sweep(2, 64);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
